uart_tx_feeder: RTL
===================

// Module: uart_tx_feeder
// PURPOSE
//  Transmit-side glue between the TX byte FIFO (socetlib_fifo) and the UartTxEn serializer.
//  Pops one byte at a time from the FIFO and presents it to UartTxEn with a one-cycle valid.
//  Waits for the frame to start and finish, then counts the byte as sent.
//  Gates new frames on software enable and optional CTS flow control.
//  Guards against a stalled serializer with a baud-tick watchdog.
// PARAMETERS
//  CTS_EN         1   1: new frames require synchronized cts_n==0; 0: cts_n ignored
//  TIMEOUT_TICKS  4   en ticks allowed in WAIT_START before timeout (>=1)
//  CNT_W          16  width of sent_count
// PORTS
//  clk          in   1      system clock
//  nReset       in   1      async active-low reset
//  en           in   1      baud tick (same txClk strobe fed to UartTxEn)
//  enable       in   1      software TX enable; gates start of new frames only
//  cts_n        in   1      external clear-to-send, active-low, asynchronous
//  flush        in   1      abort a pending (not yet issued) byte
//  clear_count  in   1      zero sent_count
//  clear_err    in   1      clear timeout_err
//  fifo_empty   in   1      TX FIFO empty
//  fifo_rdata   in   8      TX FIFO head (combinational, valid when !fifo_empty)
//  fifo_ren     out  1      FIFO pop strobe
//  tx_data      out  8      byte to UartTxEn
//  tx_valid     out  1      one-cycle load strobe to UartTxEn
//  tx_busy      in   1      UartTxEn busy
//  idle         out  1      FSM in IDLE
//  sent_count   out  CNT_W  completed frames; wraps modulo 2^CNT_W
//  timeout_err  out  1      sticky watchdog error
// BEHAVIOUR
//  Reset values: fifo_ren=0, tx_valid=0, tx_data=0, idle=1, sent_count=0, timeout_err=0.
//  Reset also forces the FSM to IDLE, the CTS sync flops to 1, and the tick counter to 0.
//  cts_n passes through a 2-flop synchronizer. cts_ok = !CTS_EN || (cts_sync==0).
//  FSM: IDLE, FETCH, LOAD, WAIT_START, WAIT_END. Outputs are decoded from the registered state.
//   IDLE:  -> FETCH when enable && !fifo_empty && cts_ok && !flush.
//   FETCH: fifo_ren=1 for exactly one cycle; tx_data<=fifo_rdata on this edge.
//          -> IDLE if flush (byte popped and discarded, not counted), else -> LOAD.
//   LOAD:  tx_valid=1 for exactly one cycle, regardless of en. Unconditional -> WAIT_START.
//          A flush in this cycle is ignored.
//   WAIT_START: tick counter cleared on entry.
//          If tx_busy: -> WAIT_END.
//          Else on each en: tick++. When tick reaches TIMEOUT_TICKS: timeout_err<=1, -> IDLE.
//          A timed-out byte is not counted.
//   WAIT_END: when !tx_busy: sent_count++, -> IDLE.
//  Latency: fifo_empty falls in IDLE cycle N -> fifo_ren at N+1 -> tx_valid at N+2.
//  Throughput: at most one frame in flight. The next FETCH happens no earlier than the cycle after WAIT_END exits.
//  Mid-frame (WAIT_START/WAIT_END) changes to enable, cts_n or flush are ignored. The frame completes.
//  clear_count with an increment in the same cycle: clear wins, sent_count=0.
//  timeout_err set and clear_err in the same cycle: set wins.
//  fifo_ren is never asserted while fifo_empty=1. No FIFO underrun is possible by construction.
//  sent_count at all-ones plus one completed frame -> 0, with no flag.
//  Reset mid-frame: all state returns to reset values. The in-flight byte is lost and not counted.
// TESTING
//  1. Push 0xA5, enable=1, cts_n=0:
//     -> fifo_ren 1 cycle, tx_valid 2 cycles after empty falls, tx_data=0xA5.
//     -> sent_count=1 after tx_busy falls.
//  2. Push 0x11,0x22,0x33 back-to-back:
//     -> three frames in order, never two tx_valid without tx_busy high/low in between.
//     -> sent_count=3, FIFO empty.
//  3. cts_n=1 with data queued:
//     -> no fifo_ren. Drop cts_n to 0 -> fifo_ren exactly 3 cycles later (2 sync + IDLE decision).
//     -> Raise cts_n mid-frame -> frame still completes.
//  4. Hold tx_busy=0 after tx_valid, TIMEOUT_TICKS=4:
//     -> timeout_err=1 on the 4th en tick, FSM IDLE, sent_count unchanged.
//     -> clear_err -> 0.
//  5. flush asserted during FETCH:
//     -> byte popped, no tx_valid, sent_count unchanged.
//     -> flush during WAIT_END has no effect.
//  6. CNT_W=4, send 16 frames:
//     -> sent_count wraps to 0.
//     -> clear_count coincident with a completion -> 0.
//     -> nReset during WAIT_END -> all outputs at reset values.

Source files
------------

// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if
//   Bundles the two handshakes the feeder sits between:
//     - the TX byte FIFO read side: fifo_empty, fifo_rdata in; fifo_ren out
//     - the UartTxEn load side: tx_data, tx_valid out; tx_busy in
//   master : the feeder (pops the FIFO, loads the serializer)
//   slave  : the FIFO + serializer side (or a testbench model of them)
interface uart_tx_feeder_if;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;
  logic       fifo_ren;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_busy;

  modport master (
    input  fifo_empty, fifo_rdata, tx_busy,
    output fifo_ren, tx_data, tx_valid
  );

  modport slave (
    output fifo_empty, fifo_rdata, tx_busy,
    input  fifo_ren, tx_data, tx_valid
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
//   Transmit-side glue between the TX byte FIFO and the UartTxEn serializer.
//   Pops one byte, hands it to the serializer with a one-cycle load strobe,
//   waits for the frame to start and finish, then counts it as sent.
//   New frames are gated by software enable and (optionally) CTS; a baud-tick
//   watchdog catches a serializer that never starts the frame.
// Ports
//   clk, nReset   system clock, asynchronous active-low reset
//   en            baud tick (same strobe that drives UartTxEn)
//   enable        software TX enable, gates only the start of a new frame
//   cts_n         external clear-to-send, active-low, asynchronous
//   flush         drop a byte that has been popped but not yet loaded
//   clear_count   zero sent_count (wins over a same-cycle increment)
//   clear_err     clear timeout_err (loses to a same-cycle set)
//   bus           FIFO read + serializer load handshakes (master side)
//   idle          FSM is in IDLE
//   sent_count    completed frames, wraps silently
//   timeout_err   sticky watchdog error
module uart_tx_feeder #(
  parameter int CTS_EN        = 1,
  parameter int TIMEOUT_TICKS = 4,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              en,
  input  logic              enable,
  input  logic              cts_n,
  input  logic              flush,
  input  logic              clear_count,
  input  logic              clear_err,
  uart_tx_feeder_if.master  bus,
  output logic              idle,
  output logic [CNT_W-1:0]  sent_count,
  output logic              timeout_err
);

  // Tick counter only has to hold 0..TIMEOUT_TICKS-1: the tick that would
  // reach TIMEOUT_TICKS fires the watchdog instead of being stored.
  localparam int TICK_W = (TIMEOUT_TICKS < 2) ? 1 : $clog2(TIMEOUT_TICKS);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    WAIT_START,
    WAIT_END
  } state_t;

  state_t             state_reg;
  logic [TICK_W-1:0]  tick_reg;
  logic               cts_meta_reg;
  logic               cts_sync_reg;
  logic               fifo_ren_reg;
  logic               tx_valid_reg;
  logic [7:0]         tx_data_reg;
  logic               idle_reg;
  logic [CNT_W-1:0]   sent_count_reg;
  logic               timeout_err_reg;

  logic cts_ok;
  logic start_ok;
  logic frame_done;
  logic watchdog_fire;

  assign cts_ok   = (CTS_EN == 0) || !cts_sync_reg;
  // fifo_empty is part of the start condition, so a pop can never hit an
  // empty FIFO: nothing else drains it while we are in FETCH.
  assign start_ok = enable && !bus.fifo_empty && cts_ok && !flush;

  assign frame_done    = (state_reg == WAIT_END) && !bus.tx_busy;
  assign watchdog_fire = (state_reg == WAIT_START) && !bus.tx_busy && en &&
                         (tick_reg == TICK_LAST);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_reg       <= IDLE;
      tick_reg        <= '0;
      cts_meta_reg    <= 1'b1;
      cts_sync_reg    <= 1'b1;
      fifo_ren_reg    <= 1'b0;
      tx_valid_reg    <= 1'b0;
      tx_data_reg     <= 8'h00;
      idle_reg        <= 1'b1;
      sent_count_reg  <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      cts_meta_reg <= cts_n;
      cts_sync_reg <= cts_meta_reg;

      // Strobes are registered and only ever raised for the single cycle
      // spent in FETCH / LOAD.
      fifo_ren_reg <= 1'b0;
      tx_valid_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (start_ok) begin
            state_reg    <= FETCH;
            fifo_ren_reg <= 1'b1;
            idle_reg     <= 1'b0;
          end
        end

        FETCH: begin
          // The pop happens this cycle regardless; flush only decides
          // whether the popped byte is handed on or thrown away.
          tx_data_reg <= bus.fifo_rdata;
          if (flush) begin
            state_reg <= IDLE;
            idle_reg  <= 1'b1;
          end else begin
            state_reg    <= LOAD;
            tx_valid_reg <= 1'b1;
          end
        end

        LOAD: begin
          state_reg <= WAIT_START;
          tick_reg  <= '0;
        end

        WAIT_START: begin
          if (bus.tx_busy) begin
            state_reg <= WAIT_END;
          end else if (watchdog_fire) begin
            state_reg <= IDLE;
            idle_reg  <= 1'b1;
          end else if (en) begin
            tick_reg <= tick_reg + TICK_W'(1);
          end
        end

        WAIT_END: begin
          if (!bus.tx_busy) begin
            state_reg <= IDLE;
            idle_reg  <= 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          idle_reg  <= 1'b1;
        end
      endcase

      if (clear_count) begin
        sent_count_reg <= '0;
      end else if (frame_done) begin
        sent_count_reg <= sent_count_reg + CNT_W'(1);
      end

      if (watchdog_fire) begin
        timeout_err_reg <= 1'b1;
      end else if (clear_err) begin
        timeout_err_reg <= 1'b0;
      end
    end
  end

  assign bus.fifo_ren = fifo_ren_reg;
  assign bus.tx_valid = tx_valid_reg;
  assign bus.tx_data  = tx_data_reg;
  assign idle         = idle_reg;
  assign sent_count   = sent_count_reg;
  assign timeout_err  = timeout_err_reg;

endmodule
